// File: rtl/ami_req_window_pkg.sv
// Shared AMI request/response types and window FSM states.
// Imported by the request window and its FIFO.
package AMITypes;

    typedef struct packed {
        logic        valid;
        logic        isWrite;
        logic [63:0] addr;
        logic [63:0] data;
        logic [7:0]  size;
    } AMIRequest;

    typedef struct packed {
        logic        valid;
        logic [63:0] data;
        logic [7:0]  size;
    } AMIResponse;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        ERROR = 2'd2
    } win_state_e;

endpackage

// File: rtl/ami_req_window_fifo.sv
// Request FIFO for one AMI channel.
// Power-of-two depth, so the pointers wrap naturally.
module ami_req_fifo
    import AMITypes::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  AMIRequest                din,
    input  logic                     pop,
    output AMIRequest                dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    AMIRequest     mem_q [DEPTH];
    AMIRequest     mem_d [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CW'(DEPTH));
    assign count = cnt_q;
    assign dout  = mem_q[rd_ptr_q];

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Next pointers, occupancy and storage contents.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointer and count registers; reset empties the queue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage array needs no reset; empty masks stale entries.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/ami_req_window.sv
// Address window for one AMI channel: relocates and bounds-checks
// requests, queues them, and throttles outstanding reads.
module ami_req_window
    import AMITypes::*;
#(
    parameter int DEPTH  = 4,
    parameter int MAX_RD = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_load,
    input  logic [47:0] cfg_base,
    input  logic [47:0] cfg_limit,
    input  logic        flush,
    input  AMIRequest   app_req,
    output logic        app_req_grant,
    output AMIRequest   mem_req,
    input  logic        mem_req_grant,
    input  AMIResponse  mem_resp,
    output logic        mem_resp_grant,
    output AMIResponse  app_resp,
    input  logic        app_resp_grant,
    output logic        idle,
    output logic        err,
    output logic [63:0] err_addr,
    output logic [31:0] req_count
);

    win_state_e  state_q, state_d;
    logic [7:0]  rd_out_q, rd_out_d;
    logic [47:0] cfg_base_q, cfg_base_d;
    logic [47:0] cfg_limit_q, cfg_limit_d;
    logic        err_q, err_d;
    logic [63:0] err_addr_q, err_addr_d;
    logic [31:0] req_count_q, req_count_d;

    AMIRequest   head;
    AMIRequest   enq;
    logic        fifo_empty;
    logic        fifo_full;
    logic [$clog2(DEPTH):0] fifo_count;
    logic [64:0] end_addr;
    logic        accept;
    logic        oob;
    logic        push;
    logic        pop;
    logic        head_blocked;
    logic        rd_inc;
    logic        rd_dec;

    ami_req_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (enq),
        .pop   (pop),
        .dout  (head),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    // Bounds check, relocation and queue handshakes.
    always_comb begin
        end_addr     = {1'b0, app_req.addr} + {57'd0, app_req.size};
        oob          = (cfg_limit_q != '0) &&
                       (end_addr > {17'd0, cfg_limit_q});
        accept       = app_req.valid && app_req_grant;
        push         = accept && !oob;
        enq          = app_req;
        enq.addr     = app_req.addr + {16'd0, cfg_base_q};
        head_blocked = !head.isWrite && (rd_out_q == 8'(MAX_RD));
        mem_req       = head;
        mem_req.valid = !fifo_empty && !head_blocked;
        pop          = mem_req.valid && mem_req_grant;
        rd_inc       = pop && !head.isWrite;
        rd_dec       = mem_resp.valid && app_resp_grant;
    end

    // Responses pass straight through with no buffering.
    always_comb begin
        app_resp       = mem_resp;
        mem_resp_grant = app_resp_grant;
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= RUN;
        else     state_q <= state_d;
    end

    // FSM next state; a violation wins over a same-cycle flush.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (accept && oob) state_d = ERROR;
                else if (flush)    state_d = DRAIN;
            end
            ERROR: begin
                if (flush) state_d = DRAIN;
            end
            DRAIN: begin
                if (fifo_empty && rd_out_q == '0) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    // FSM outputs.
    always_comb begin
        app_req_grant = (state_q == RUN) && !fifo_full;
        idle          = (state_q == RUN) && fifo_empty &&
                        (rd_out_q == '0);
    end

    // Read tracking, configuration, error capture and counters.
    always_comb begin
        rd_out_d    = rd_out_q;
        cfg_base_d  = cfg_base_q;
        cfg_limit_d = cfg_limit_q;
        err_d       = err_q;
        err_addr_d  = err_addr_q;
        req_count_d = req_count_q;
        unique case ({rd_inc, rd_dec})
            2'b10: rd_out_d = rd_out_q + 8'd1;
            2'b01: begin
                // Late responses after reset must not underflow.
                if (rd_out_q != '0) rd_out_d = rd_out_q - 8'd1;
            end
            default: rd_out_d = rd_out_q;
        endcase
        if (cfg_load && idle) begin
            cfg_base_d  = cfg_base;
            cfg_limit_d = cfg_limit;
            err_d       = 1'b0;
            err_addr_d  = '0;
            req_count_d = '0;
        end else if (pop) begin
            req_count_d = req_count_q + 32'd1;
        end
        if (accept && oob) begin
            err_d = 1'b1;
            if (!err_q) err_addr_d = app_req.addr;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_out_q    <= '0;
            cfg_base_q  <= '0;
            cfg_limit_q <= '0;
            err_q       <= 1'b0;
            err_addr_q  <= '0;
            req_count_q <= '0;
        end else begin
            rd_out_q    <= rd_out_d;
            cfg_base_q  <= cfg_base_d;
            cfg_limit_q <= cfg_limit_d;
            err_q       <= err_d;
            err_addr_q  <= err_addr_d;
            req_count_q <= req_count_d;
        end
    end

    assign err       = err_q;
    assign err_addr  = err_addr_q;
    assign req_count = req_count_q;

endmodule

// File: tb/tb_ami_req_window.sv
// Directed scoreboard bench for ami_req_window.
// Expected memory requests are queued; a monitor checks each handshake.
module tb_ami_req_window;
    import AMITypes::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_load = 1'b0;
    logic [47:0] cfg_base = '0;
    logic [47:0] cfg_limit = '0;
    logic        flush = 1'b0;
    AMIRequest   app_req = '0;
    logic        app_req_grant;
    AMIRequest   mem_req;
    logic        mem_req_grant = 1'b0;
    AMIResponse  mem_resp = '0;
    logic        mem_resp_grant;
    AMIResponse  app_resp;
    logic        app_resp_grant = 1'b0;
    logic        idle;
    logic        err;
    logic [63:0] err_addr;
    logic [31:0] req_count;

    int checks = 0;
    int passed = 0;
    AMIRequest sb[$];

    ami_req_window #(
        .DEPTH (4),
        .MAX_RD(2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_load       (cfg_load),
        .cfg_base       (cfg_base),
        .cfg_limit      (cfg_limit),
        .flush          (flush),
        .app_req        (app_req),
        .app_req_grant  (app_req_grant),
        .mem_req        (mem_req),
        .mem_req_grant  (mem_req_grant),
        .mem_resp       (mem_resp),
        .mem_resp_grant (mem_resp_grant),
        .app_resp       (app_resp),
        .app_resp_grant (app_resp_grant),
        .idle           (idle),
        .err            (err),
        .err_addr       (err_addr),
        .req_count      (req_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [159:0] act,
                       input logic [159:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    endtask

    // Monitor: every memory handshake must match the queue head.
    always @(negedge clk) begin
        if (!rst && mem_req.valid && mem_req_grant) begin
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL mem_req_unexpected actual=%0h required=none",
                         mem_req.addr);
            end else begin
                chk("mem_req", mem_req, sb.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one request for one cycle; queue its translation if taken.
    task automatic send(input logic w, input logic [63:0] a,
                        input logic [7:0] sz, input logic [63:0] exp_a,
                        input bit in_bounds, output bit granted);
        AMIRequest e;
        app_req = '{valid: 1'b1, isWrite: w, addr: a,
                    data: a ^ 64'hA5A5, size: sz};
        @(negedge clk);
        granted = app_req_grant;
        if (granted && in_bounds) begin
            e = app_req;
            e.addr = exp_a;
            sb.push_back(e);
        end
        tick();
        app_req.valid = 1'b0;
    endtask

    task automatic load(input logic [47:0] b, input logic [47:0] l);
        cfg_base = b;
        cfg_limit = l;
        cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
    endtask

    task automatic resp(input int n, input logic [63:0] d);
        mem_resp = '{valid: 1'b1, data: d, size: 8'd64};
        app_resp_grant = 1'b1;
        repeat (n) tick();
        mem_resp.valid = 1'b0;
        app_resp_grant = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        bit g;
        int ng;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_valid", mem_req.valid, 0);
        chk("rst_grant", app_req_grant, 1);
        chk("rst_idle", idle, 1);
        chk("rst_err", err, 0);
        chk("rst_err_addr", err_addr, 0);
        chk("rst_req_count", req_count, 0);
        tick();
        rst = 1'b0;
        tick();

        // Relocation and one-cycle latency.
        load(48'h1000, 48'h0);
        mem_req_grant = 1'b1;
        send(1'b0, 64'h40, 8'd64, 64'h1040, 1, g);
        @(negedge clk);
        chk("latency1", mem_req.valid, 1);
        tick();
        @(negedge clk);
        chk("req_count1", req_count, 1);
        tick();
        mem_resp = '{valid: 1'b1, data: 64'hBEEF0001, size: 8'd64};
        app_resp_grant = 1'b1;
        #1;
        chk("resp_pass", app_resp, {1'b1, 64'hBEEF0001, 8'd64});
        chk("resp_grant", mem_resp_grant, 1);
        tick();
        mem_resp.valid = 1'b0;
        app_resp_grant = 1'b0;
        @(negedge clk);
        chk("idle_after_resp", idle, 1);
        tick();

        // FIFO fills at DEPTH while memory stalls.
        mem_req_grant = 1'b0;
        ng = 0;
        for (int i = 1; i <= 6; i++) begin
            send(1'b1, 64'(i) << 8, 8'd8, 64'h1000 + (64'(i) << 8), 1, g);
            ng += int'(g);
        end
        chk("grant_count", ng, 4);
        @(negedge clk);
        chk("full_no_grant", app_req_grant, 0);
        tick();
        mem_req_grant = 1'b1;
        tick();
        @(negedge clk);
        chk("grant_after_pop", app_req_grant, 1);
        repeat (6) tick();
        chk("req_count5", req_count, 5);
        chk("sb_drained1", sb.size(), 0);

        // Read throttle at MAX_RD=2.
        send(1'b0, 64'h200, 8'd64, 64'h1200, 1, g);
        send(1'b0, 64'h300, 8'd64, 64'h1300, 1, g);
        send(1'b0, 64'h400, 8'd64, 64'h1400, 1, g);
        tick();
        tick();
        @(negedge clk);
        chk("rd_hold", mem_req.valid, 0);
        chk("rd_hold_idle", idle, 0);
        tick();
        mem_resp = '{valid: 1'b1, data: 64'h11, size: 8'd64};
        app_resp_grant = 1'b1;
        @(negedge clk);
        chk("rd_hold_resp_cycle", mem_req.valid, 0);
        tick();
        mem_resp.valid = 1'b0;
        app_resp_grant = 1'b0;
        @(negedge clk);
        chk("rd_release", mem_req.valid, 1);
        tick();
        resp(2, 64'h22);
        @(negedge clk);
        chk("rd_idle", idle, 1);
        tick();

        // Bounds: end == limit passes, end > limit is an error.
        load(48'h0, 48'h100);
        send(1'b1, 64'hC0, 8'd64, 64'hC0, 1, g);
        repeat (3) tick();
        send(1'b1, 64'hC0, 8'd65, 64'h0, 0, g);
        @(negedge clk);
        chk("oob_err", err, 1);
        chk("oob_err_addr", err_addr, 64'hC0);
        chk("oob_state", dut.state_q, ERROR);
        chk("oob_no_grant", app_req_grant, 0);
        chk("oob_no_mem", mem_req.valid, 0);
        tick();
        load(48'h5000, 48'h0);
        @(negedge clk);
        chk("cfg_ignored", err, 1);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clk);
        chk("flush_drain", dut.state_q, DRAIN);
        tick();
        @(negedge clk);
        chk("drain_run", dut.state_q, RUN);
        chk("err_sticky", err, 1);
        chk("run_idle", idle, 1);
        tick();
        load(48'h2000, 48'h0);
        @(negedge clk);
        chk("cfg_clr_err", err, 0);
        chk("cfg_clr_addr", err_addr, 0);
        chk("cfg_clr_cnt", req_count, 0);
        tick();

        // Reset with reads outstanding and requests queued.
        send(1'b0, 64'h10, 8'd64, 64'h2010, 1, g);
        send(1'b0, 64'h20, 8'd64, 64'h2020, 1, g);
        tick();
        tick();
        mem_req_grant = 1'b0;
        send(1'b1, 64'h30, 8'd8, 64'h2030, 1, g);
        send(1'b1, 64'h40, 8'd8, 64'h2040, 1, g);
        send(1'b1, 64'h50, 8'd8, 64'h2050, 1, g);
        @(negedge clk);
        chk("pre_rst_valid", mem_req.valid, 1);
        rst = 1'b1;
        #1;
        chk("rst_async_valid", mem_req.valid, 0);
        chk("rst_async_grant", app_req_grant, 1);
        sb.delete();
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", idle, 1);
        chk("post_rst_valid", mem_req.valid, 0);
        tick();
        mem_resp = '{valid: 1'b1, data: 64'h77, size: 8'd64};
        app_resp_grant = 1'b1;
        #1;
        chk("late_resp", app_resp, {1'b1, 64'h77, 8'd64});
        tick();
        mem_resp.valid = 1'b0;
        app_resp_grant = 1'b0;
        @(negedge clk);
        chk("late_resp_idle", idle, 1);
        chk("sb_final", sb.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
